uart_rx_param: RTL

Parametrised UART receiver, successor to the fixed 8N1 receiver. It supports configurable data width, optional even/odd parity, and 1 or 2 stop bits. It adds a false-start reject, framing/parity error reporting, break recovery and a valid/ready output holding register with overrun detection. It sits between the board serial pin and any byte consumer, such as a BCD display decoder or a FIFO.

---
 rtl/uart_rx_param.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with parity, stop-bit, break and overrun handling
//
// Ports:
//   clock      system clock
//   reset      asynchronous, active-low reset
//   serial     asynchronous serial line, idle high
//   data       received word, bit 0 is the first bit on the line
//   valid      data and error flags are valid; held until accepted
//   ready      consumer accepts the word when valid && ready on a clock edge
//   parity_err parity mismatch for the held word (qualified by valid)
//   frame_err  a stop bit sampled low for the held word (qualified by valid)
//   overrun    one-cycle pulse: a completed word was dropped, holding register full
//   busy       receiver FSM is not idle
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 serial,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] MID      = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
    localparam int            IW       = $clog2(DATA_BITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
    localparam bit            TWO_STOP = (STOP_BITS == 2);
    localparam bit            HAS_PAR  = (PARITY_MODE != 0);
    localparam bit            ODD_PAR  = (PARITY_MODE == 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK_WAIT
    } state_t;

    state_t state, state_next;

    logic                 sync_1, sync_2, rx_prev;
    logic                 rx, rx_fall;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_err_r, frm_err_r;
    logic                 mid, last_stop, done, done_frame_err;

    assign rx        = sync_2;
    assign rx_fall   = rx_prev & ~rx;
    assign mid       = (cnt == MID);
    assign last_stop = !TWO_STOP || stop_idx;
    // Word completes on the mid-sample of the final stop bit.
    assign done      = (state == STOP) && mid && last_stop;
    // Includes the stop sample being taken this very cycle.
    assign done_frame_err = frm_err_r | ~rx;
    assign busy      = (state != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_1  <= 1'b1;
            sync_2  <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync_1  <= serial;
            sync_2  <= sync_1;
            rx_prev <= sync_2;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:       if (rx_fall) state_next = START;
            START:      if (mid) state_next = rx ? IDLE : DATA;
            DATA:       if (mid && bit_idx == LAST_IDX) state_next = HAS_PAR ? PARITY : STOP;
            PARITY:     if (mid) state_next = STOP;
            STOP:       if (done) state_next = done_frame_err ? BREAK_WAIT : IDLE;
            BREAK_WAIT: if (rx) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            shreg     <= '0;
            par_err_r <= 1'b0;
            frm_err_r <= 1'b0;
        end else begin
            // Counter is parked at zero in IDLE so START always begins a fresh bit.
            if (state == IDLE || state_next == IDLE) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end

            unique case (state)
                START: begin
                    bit_idx   <= '0;
                    stop_idx  <= 1'b0;
                    par_err_r <= 1'b0;
                    frm_err_r <= 1'b0;
                end
                DATA: if (mid) begin
                    // LSB first: after DATA_BITS shifts the first bit sits in bit 0.
                    shreg   <= {rx, shreg[DATA_BITS-1:1]};
                    bit_idx <= bit_idx + IW'(1);
                end
                PARITY: if (mid) begin
                    par_err_r <= (^shreg) ^ rx ^ ODD_PAR;
                end
                STOP: if (mid) begin
                    if (!rx) frm_err_r <= 1'b1;
                    stop_idx <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done) begin
                if (!valid || ready) begin
                    data       <= shreg;
                    parity_err <= par_err_r;
                    frame_err  <= done_frame_err;
                    valid      <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule
